// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic MARK  = 1'b1;
    localparam logic SPACE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Per-bit timer: counts 0..CLKS_PER_BIT-1 while run is high, pulses bit_end on the last count.
module fifo_uart_tx_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end = run && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a sync FIFO and serialises each as a UART frame on tx.
// The FIFO drops a read issued alongside a write, so the write strobe is snooped.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic       fifo_wr_snoop,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 byte_done_q, byte_done_d;
    logic                 run, bit_end, accepted;

    // A read presented with a non-dropped write is discarded by the FIFO.
    assign accepted = !fifo_empty && !(fifo_wr_snoop && !fifo_full);
    assign run      = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);

    fifo_uart_tx_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (!run),
        .run    (run),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        parity_d    = parity_q;
        tx_d        = tx_q;
        byte_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = accepted ? LOAD : IDLE;
            end
            LOAD: begin
                shift_d  = fifo_data;
                parity_d = (PARITY_ODD != 0) ? ~^fifo_data : ^fifo_data;
                tx_d     = SPACE;
                state_d  = START;
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LastData) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = MARK;
                            state_d = STOP;
                        end
                    end else begin
                        // tx is registered, so present the next bit as we shift.
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = MARK;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LastStop) begin
                        bit_idx_d   = '0;
                        byte_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            parity_q    <= 1'b0;
            tx_q        <= MARK;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign fifo_rd   = (state_q == REQ);
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;
    assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three transmitter lanes (8N1, 8O1, 8E2) fed by queue-based FIFO models; a frame-level
// line monitor compares every sampled tx cycle against the frame built from the popped byte.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int NL    = 3;
    localparam int DEPTH = 16;
    localparam int PEN  [NL] = '{0, 1, 1};
    localparam int PODD [NL] = '{0, 1, 0};
    localparam int SB   [NL] = '{1, 1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic wr = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [NL-1:0] empty, full, rd, tx, busy, done;
    logic [7:0] rdata [NL];
    logic [7:0] q      [NL][$];
    logic [7:0] popped [NL][$];

    int qn         [NL] = '{0, 0, 0};
    int rd_cnt     [NL] = '{0, 0, 0};
    int rd_empty   [NL] = '{0, 0, 0};
    int rx_cnt     [NL] = '{0, 0, 0};
    int done_cnt   [NL] = '{0, 0, 0};
    int mon_idx    [NL] = '{-1, -1, -1};
    int extra_done [NL] = '{0, 0, 0};
    int last_end   [NL] = '{-1, -1, -1};
    int last_gap   [NL] = '{0, 0, 0};
    int rd_cyc     [NL] = '{-100, -100, -100};
    logic [63:0] got  [NL];
    logic [63:0] expv [NL];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty[0]), .fifo_full(full[0]),
        .fifo_wr_snoop(wr), .fifo_data(rdata[0]), .fifo_rd(rd[0]), .tx(tx[0]), .busy(busy[0]),
        .byte_done(done[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty[1]), .fifo_full(full[1]),
        .fifo_wr_snoop(wr), .fifo_data(rdata[1]), .fifo_rd(rd[1]), .tx(tx[1]), .busy(busy[1]),
        .byte_done(done[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty[2]), .fifo_full(full[2]),
        .fifo_wr_snoop(wr), .fifo_data(rdata[2]), .fifo_rd(rd[2]), .tx(tx[2]), .busy(busy[2]),
        .byte_done(done[2]));

    task automatic check(string tag, logic [63:0] obs, logic [63:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic int frame_len(int l);
        return (9 + PEN[l] + SB[l]) * CPB;
    endfunction

    // Line level of every clock cycle of a frame, start bit at index 0.
    function automatic logic [63:0] frame_vec(int l, logic [7:0] d);
        logic [11:0] bits;
        logic [63:0] vec;
        int nb;
        bits = '0;
        vec  = '0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (PEN[l] != 0) begin
            bits[nb] = (PODD[l] != 0) ? ~^d : ^d;
            nb++;
        end
        for (int s = 0; s < SB[l]; s++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < CPB; c++) vec[b*CPB+c] = bits[b];
        return vec;
    endfunction

    always_comb begin
        empty = '0;
        full  = '0;
        for (int l = 0; l < NL; l++) begin
            empty[l] = (qn[l] == 0);
            full[l]  = (qn[l] >= DEPTH);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: write wins; a read alongside an accepted write is dropped.
    always @(posedge clk) begin : fifo_model
        logic w_ok, r_ok;
        for (int l = 0; l < NL; l++) begin
            w_ok = wr && (qn[l] < DEPTH);
            r_ok = rd[l] && (qn[l] > 0) && !w_ok;
            if (rd[l] && qn[l] == 0) rd_empty[l]++;
            if (w_ok) q[l].push_back(wdata);
            if (r_ok) begin
                rdata[l] <= q[l][0];
                popped[l].push_back(q[l][0]);
                void'(q[l].pop_front());
                rd_cnt[l]++;
                rd_cyc[l] = cyc;
            end
            qn[l] <= qn[l] + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
            if (rst) popped[l].delete();
        end
    end

    always @(negedge clk) begin : line_monitor
        for (int l = 0; l < NL; l++) begin
            if (done[l]) done_cnt[l]++;
            if (rst) begin
                mon_idx[l] = -1;
            end else if (mon_idx[l] < 0) begin
                if (done[l]) check($sformatf("done_idle%0d", l), 64'd1, 64'd0);
                if (tx[l] == 1'b0) begin
                    check($sformatf("frame_has_byte%0d", l), 64'(popped[l].size() > 0), 64'd1);
                    expv[l] = (popped[l].size() > 0) ? frame_vec(l, popped[l][0]) : '1;
                    check($sformatf("rd_to_fall%0d", l), 64'(cyc - rd_cyc[l]), 64'd2);
                    if (last_end[l] >= 0) last_gap[l] = cyc - last_end[l];
                    got[l]        = '0;
                    extra_done[l] = 0;
                    mon_idx[l]    = 1;
                end
            end else if (mon_idx[l] < frame_len(l)) begin
                got[l][mon_idx[l]] = tx[l];
                if (done[l]) extra_done[l]++;
                mon_idx[l]++;
            end else begin
                check($sformatf("byte_done%0d", l), 64'(done[l]), 64'd1);
                check($sformatf("done_early%0d", l), 64'(extra_done[l]), 64'd0);
                check($sformatf("frame%0d", l), got[l], expv[l]);
                if (popped[l].size() > 0) void'(popped[l].pop_front());
                rx_cnt[l]++;
                last_end[l] = cyc;
                mon_idx[l]  = -1;
            end
        end
    end

    task automatic push(logic [7:0] d);
        wr    = 1'b1;
        wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    function automatic bit all_idle();
        for (int l = 0; l < NL; l++)
            if (busy[l] || qn[l] != 0 || mon_idx[l] >= 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(string tag);
        int n = 0;
        while (n < 4000 && !all_idle()) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 64'(n < 4000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    int rd0 [NL];
    int rx0 [NL];
    int dn0 [NL];

    task automatic snap();
        for (int l = 0; l < NL; l++) begin
            rd0[l] = rd_cnt[l];
            rx0[l] = rx_cnt[l];
            dn0[l] = done_cnt[l];
        end
    endtask

    task automatic check_deltas(string tag, int nrd, int nrx, int ndn);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("%s_reads%0d", tag, l), 64'(rd_cnt[l] - rd0[l]), 64'(nrd));
            check($sformatf("%s_frames%0d", tag, l), 64'(rx_cnt[l] - rx0[l]), 64'(nrx));
            check($sformatf("%s_dones%0d", tag, l), 64'(done_cnt[l] - dn0[l]), 64'(ndn));
        end
    endtask

    initial begin
        int n;
        // Reset held with a byte sitting in the FIFO.
        repeat (2) @(negedge clk);
        push(8'hA5);
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("rst_tx%0d", l), 64'(tx[l]), 64'd1);
            check($sformatf("rst_rd%0d", l), 64'(rd[l]), 64'd0);
            check($sformatf("rst_busy%0d", l), 64'(busy[l]), 64'd0);
            check($sformatf("rst_done%0d", l), 64'(done[l]), 64'd0);
        end
        snap();
        rst = 1'b0;

        // Single byte 0xA5.
        wait_idle("a5");
        check_deltas("a5", 1, 1, 1);

        // Write collides with the read: rejected, retried two cycles later.
        snap();
        push(8'h3C);
        @(negedge clk);
        check("snoop_req", 64'(rd[0]), 64'd1);
        push(8'hC3);
        check("snoop_reject", 64'(rd[0]), 64'd0);
        @(negedge clk);
        check("snoop_retry", 64'(rd[0]), 64'd1);
        wait_idle("snoop");
        check_deltas("snoop", 2, 2, 2);

        // Back-to-back frames.
        snap();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        wait_idle("b2b");
        check_deltas("b2b", 3, 3, 3);
        for (int l = 0; l < NL; l++) check($sformatf("gap%0d", l), 64'(last_gap[l]), 64'd3);

        // Parity corner bytes.
        snap();
        push(8'h01);
        push(8'h03);
        push(8'h07);
        wait_idle("par");
        check_deltas("par", 3, 3, 3);

        // Reset during data bit 3.
        snap();
        push(8'h96);
        n = 0;
        while (n < 200 && mon_idx[0] != 18) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_bit3", 64'(n < 200), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("abort_tx%0d", l), 64'(tx[l]), 64'd1);
            check($sformatf("abort_busy%0d", l), 64'(busy[l]), 64'd0);
        end
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check_deltas("abort", 1, 0, 0);

        // enable dropped mid-frame: frame completes, next byte stays queued.
        snap();
        push(8'h5A);
        push(8'hE1);
        n = 0;
        while (n < 200 && mon_idx[0] != 10) begin
            @(negedge clk);
            n++;
        end
        check("en_reach_mid", 64'(n < 200), 64'd1);
        enable = 1'b0;
        repeat (120) @(negedge clk);
        check_deltas("en_low", 1, 1, 1);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("en_low_busy%0d", l), 64'(busy[l]), 64'd0);
            check($sformatf("en_low_queued%0d", l), 64'(qn[l]), 64'd1);
        end
        enable = 1'b1;
        wait_idle("en_resume");

        // Random writes (including collisions and full FIFO) and enable toggling.
        for (int i = 0; i < 1500; i++) begin
            wr    = ($urandom_range(0, 5) == 0);
            wdata = 8'($urandom);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            @(negedge clk);
        end
        wr     = 1'b0;
        enable = 1'b1;
        wait_idle("rand");
        for (int l = 0; l < NL; l++) begin
            check($sformatf("rx_vs_rd%0d", l), 64'(rx_cnt[l]), 64'(rd_cnt[l] - 1));
            check($sformatf("rd_while_empty%0d", l), 64'(rd_empty[l]), 64'd0);
            check($sformatf("leftover%0d", l), 64'(popped[l].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
